// File: rtl/tt_trng_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_trng_pkg : shared state encoding and counter sizing for the TRNG  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package tt_trng_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WARMUP  = 3'd1,
      ST_COLLECT = 3'd2,
      ST_VALID   = 3'd3,
      ST_FAIL    = 3'd4
   } state_e;

   // Width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      if (n > 1) w = $clog2(n);
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_trng_health.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_trng_health : repetition-count health test on captured bits       |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tt_trng_health
   import tt_trng_pkg::*;
#(
   parameter int unsigned REP_LIMIT = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic bit_valid_i,
   input  logic bit_i,
   output logic fail_pulse_o
);

   localparam int unsigned RUN_W = cnt_width(REP_LIMIT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(REP_LIMIT);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   logic [RUN_W-1:0] run_q, run_d;
   logic             prev_q;

   // A zero run means no bit has been seen since the last clear.
   always_comb begin
      run_d = run_q;
      if (bit_valid_i) begin
         if ((run_q != '0) && (bit_i == prev_q)) begin
            if (run_q != RUN_MAX) run_d = run_q + RUN_ONE;
         end else begin
            run_d = RUN_ONE;
         end
      end
   end

   assign fail_pulse_o = bit_valid_i && (run_d == RUN_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q  <= '0;
         prev_q <= 1'b0;
      end else if (clr_i) begin
         run_q  <= '0;
      end else if (bit_valid_i) begin
         run_q  <= run_d;
         prev_q <= bit_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tt_trng_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_trng_ctrl : TRNG sequencer - ring warm-up, paced sampling, key    |
// |                assembly, health test and valid/ready key hand-off    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tt_trng_ctrl
   import tt_trng_pkg::*;
#(
   parameter int unsigned WARMUP_CYCLES = 256,
   parameter int unsigned SAMPLE_DIV    = 16,
   parameter int unsigned KEY_W         = 4,
   parameter int unsigned REP_LIMIT     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             rnd_bit_i,
   input  logic             key_ready_i,
   input  logic             clear_fail_i,
   output logic             ring_en_o,
   output logic             sample_o,
   output logic [KEY_W-1:0] key_o,
   output logic             key_valid_o,
   output logic             busy_o,
   output logic             fail_o
);

   localparam int unsigned WARM_W = cnt_width(WARMUP_CYCLES);
   localparam int unsigned DIV_W  = cnt_width(SAMPLE_DIV);
   localparam int unsigned BIT_W  = cnt_width(KEY_W);

   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
   localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(KEY_W - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   state_e              state_q, state_d;
   logic [WARM_W-1:0]   warm_q, warm_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bcnt_q, bcnt_d;
   logic [KEY_W-1:0]    key_sr_q, key_sr_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic                ring_en_q, sample_q, key_valid_q, busy_q, fail_q;

   logic                capture;
   logic                health_clr;
   logic                health_fail;

   assign capture    = (state_q == ST_COLLECT) && (div_q == DIV_LAST);
   assign health_clr = (state_q == ST_IDLE) || ((state_q == ST_FAIL) && clear_fail_i);

   tt_trng_health #(
      .REP_LIMIT (REP_LIMIT)
   ) u_health (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (health_clr),
      .bit_valid_i  (capture),
      .bit_i        (rnd_bit_i),
      .fail_pulse_o (health_fail)
   );

   always_comb begin
      state_d  = state_q;
      warm_d   = warm_q;
      div_d    = div_q;
      bcnt_d   = bcnt_q;
      key_sr_d = key_sr_q;
      key_d    = key_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_WARMUP;
               warm_d  = '0;
            end
         end
         ST_WARMUP: begin
            if (warm_q == WARM_LAST) begin
               state_d = ST_COLLECT;
               div_d   = '0;
               bcnt_d  = '0;
            end else begin
               warm_d  = warm_q + WARM_ONE;
            end
         end
         ST_COLLECT: begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
            if (capture) begin
               key_sr_d = (key_sr_q << 1) | KEY_W'(rnd_bit_i);
               // A health failure on the last bit wins over key completion.
               if (health_fail) begin
                  state_d = ST_FAIL;
               end else if (bcnt_q == BIT_LAST) begin
                  state_d = ST_VALID;
                  key_d   = key_sr_d;
                  bcnt_d  = '0;
               end else begin
                  bcnt_d  = bcnt_q + BIT_ONE;
               end
            end
         end
         ST_VALID: begin
            if (key_ready_i) begin
               if (start_i) begin
                  state_d = ST_COLLECT;
                  div_d   = '0;
                  bcnt_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FAIL: begin
            if (clear_fail_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so they land registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         warm_q      <= '0;
         div_q       <= '0;
         bcnt_q      <= '0;
         key_sr_q    <= '0;
         key_q       <= '0;
         ring_en_q   <= 1'b0;
         sample_q    <= 1'b0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         warm_q      <= warm_d;
         div_q       <= div_d;
         bcnt_q      <= bcnt_d;
         key_sr_q    <= key_sr_d;
         key_q       <= key_d;
         ring_en_q   <= (state_d == ST_WARMUP) || (state_d == ST_COLLECT) ||
                        (state_d == ST_VALID);
         sample_q    <= (state_d == ST_COLLECT) && (div_d == DIV_LAST);
         key_valid_q <= (state_d == ST_VALID);
         busy_q      <= (state_d == ST_WARMUP) || (state_d == ST_COLLECT);
         fail_q      <= (state_d == ST_FAIL);
      end
   end

   assign ring_en_o   = ring_en_q;
   assign sample_o    = sample_q;
   assign key_o       = key_q;
   assign key_valid_o = key_valid_q;
   assign busy_o      = busy_q;
   assign fail_o      = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_trng_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tt_trng_ctrl : randomized self-checking bench for tt_trng_ctrl    |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_tt_trng_ctrl;

   localparam int W = 8;
   localparam int D = 4;
   localparam int K = 4;
   localparam int R = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start_i = 1'b0;
   logic         rnd_bit_i = 1'b0;
   logic         key_ready_i = 1'b0;
   logic         clear_fail_i = 1'b0;
   logic         ring_en_o, sample_o, key_valid_o, busy_o, fail_o;
   logic [K-1:0] key_o;

   int           n_chk = 0;
   int           n_err = 0;
   logic [K-1:0] last_key = '0;
   bit           hist[$];
   bit           src[$];

   tt_trng_ctrl #(
      .WARMUP_CYCLES (W),
      .SAMPLE_DIV    (D),
      .KEY_W         (K),
      .REP_LIMIT     (R)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .rnd_bit_i    (rnd_bit_i),
      .key_ready_i  (key_ready_i),
      .clear_fail_i (clear_fail_i),
      .ring_en_o    (ring_en_o),
      .sample_o     (sample_o),
      .key_o        (key_o),
      .key_valid_o  (key_valid_o),
      .busy_o       (busy_o),
      .fail_o       (fail_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Length of the trailing run of identical bits captured since IDLE.
   function automatic int run_len();
      int n;
      n = 0;
      if (hist.size() == 0) return 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] == hist[hist.size() - 1]) n++;
         else break;
      end
      return n;
   endfunction

   function automatic bit next_bit();
      if (src.size() != 0) return src.pop_front();
      return bit'($urandom_range(0, 1));
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_ring"},  ring_en_o,   0);
      check({tag, "_samp"},  sample_o,    0);
      check({tag, "_key"},   key_o,       0);
      check({tag, "_valid"}, key_valid_o, 0);
      check({tag, "_busy"},  busy_o,      0);
      check({tag, "_fail"},  fail_o,      0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         rnd_bit_i    = 1'($urandom_range(0, 1));
         key_ready_i  = 1'($urandom_range(0, 1));
         clear_fail_i = 1'($urandom_range(0, 1));
         check("idle_ring", ring_en_o, 0);
         check("idle_busy", busy_o, 0);
         check("idle_valid", key_valid_o, 0);
         check("idle_samp", sample_o, 0);
         check("idle_fail", fail_o, 0);
         step();
      end
      key_ready_i  = 1'b0;
      clear_fail_i = 1'b0;
   endtask

   task automatic start_idle();
      hist.delete();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   // Strobe k of a key arrives lead cycles from now for k=0, then every D cycles.
   task automatic do_collect(input int lead, output bit failed, output logic [K-1:0] key);
      bit b;
      int gap;
      failed = 1'b0;
      key    = '0;
      for (int s = 0; s < K; s++) begin
         gap = (s == 0) ? lead : D - 1;
         for (int i = 0; i < gap; i++) begin
            rnd_bit_i   = 1'($urandom_range(0, 1));
            start_i     = 1'($urandom_range(0, 1));
            check("gap_samp", sample_o, 0);
            check("gap_ring", ring_en_o, 1);
            check("gap_busy", busy_o, 1);
            check("gap_valid", key_valid_o, 0);
            step();
         end
         start_i   = 1'b0;
         b         = next_bit();
         rnd_bit_i = b;
         check("strobe", sample_o, 1);
         check("strobe_busy", busy_o, 1);
         step();
         hist.push_back(b);
         key = (key << 1) | K'(b);
         if (run_len() >= R) begin
            failed = 1'b1;
            return;
         end
      end
   endtask

   task automatic after_collect(input bit failed, input logic [K-1:0] key);
      if (failed) begin
         check("hf_fail", fail_o, 1);
         check("hf_ring", ring_en_o, 0);
         check("hf_valid", key_valid_o, 0);
         check("hf_busy", busy_o, 0);
         check("hf_key_kept", key_o, last_key);
      end else begin
         check("kv_valid", key_valid_o, 1);
         check("kv_key", key_o, key);
         check("kv_ring", ring_en_o, 1);
         check("kv_busy", busy_o, 0);
         check("kv_samp", sample_o, 0);
         last_key = key;
      end
   endtask

   task automatic hold_valid(input int n);
      for (int i = 0; i < n; i++) begin
         start_i      = 1'($urandom_range(0, 1));
         clear_fail_i = 1'($urandom_range(0, 1));
         rnd_bit_i    = 1'($urandom_range(0, 1));
         check("bp_valid", key_valid_o, 1);
         check("bp_key", key_o, last_key);
         check("bp_samp", sample_o, 0);
         check("bp_ring", ring_en_o, 1);
         check("bp_fail", fail_o, 0);
         step();
      end
      start_i      = 1'b0;
      clear_fail_i = 1'b0;
   endtask

   task automatic handshake(input bit cont);
      key_ready_i = 1'b1;
      start_i     = cont;
      step();
      key_ready_i = 1'b0;
      start_i     = 1'b0;
      check("hs_valid", key_valid_o, 0);
      check("hs_key", key_o, last_key);
      check("hs_ring", ring_en_o, 32'(cont));
      check("hs_busy", busy_o, 32'(cont));
   endtask

   task automatic fail_hold(input int n);
      for (int i = 0; i < n; i++) begin
         start_i = 1'($urandom_range(0, 1));
         check("fh_fail", fail_o, 1);
         check("fh_ring", ring_en_o, 0);
         check("fh_valid", key_valid_o, 0);
         step();
      end
      start_i      = 1'b0;
      clear_fail_i = 1'b1;
      step();
      clear_fail_i = 1'b0;
      check("clr_fail", fail_o, 0);
      check("clr_ring", ring_en_o, 0);
      check("clr_busy", busy_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit           f;
      bit           cont;
      logic [K-1:0] k;

      // Asynchronous reset between clock edges, start_i held meanwhile.
      #2 rst = 1'b1;
      #1 check_zero("rst_async");
      start_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_zero("rst_hold");
      end
      #3 rst = 1'b0;
      start_i = 1'b0;
      step();
      idle_cycles(2);

      // Nominal key 1,0,1,1 followed by a two-cycle wait and a plain handshake.
      src = '{1'b1, 1'b0, 1'b1, 1'b1};
      start_idle();
      do_collect(W + D - 1, f, k);
      after_collect(f, k);
      check("nominal_key_B", key_o, 4'hB);
      hold_valid(2);
      handshake(1'b0);
      idle_cycles(2);

      // Ten cycles of backpressure.
      start_idle();
      do_collect(W + D - 1, f, k);
      after_collect(f, k);
      if (!f) begin
         hold_valid(10);
         handshake(1'b0);
      end else begin
         fail_hold(1);
      end
      idle_cycles(1);

      // Health failure across back-to-back keys with a constant-one stream.
      src.delete();
      for (int i = 0; i < 8; i++) src.push_back(1'b1);
      start_idle();
      do_collect(W + D - 1, f, k);
      after_collect(f, k);
      check("hf_first_key", key_o, 4'hF);
      hold_valid(2);
      handshake(1'b1);
      do_collect(D - 1, f, k);
      check("hf_detected", 32'(f), 1);
      after_collect(f, k);
      src.delete();
      fail_hold(3);
      idle_cycles(1);

      // Reset in the middle of collection, then a full restart.
      start_idle();
      for (int i = 0; i < 17; i++) begin
         rnd_bit_i = 1'($urandom_range(0, 1));
         step();
      end
      #2 rst = 1'b1;
      #1 check_zero("rst_mid");
      start_i = 1'b1;
      step();
      check_zero("rst_mid_hold");
      #2 rst = 1'b0;
      start_i = 1'b0;
      hist.delete();
      last_key = '0;
      step();
      idle_cycles(1);
      start_idle();
      do_collect(W + D - 1, f, k);
      after_collect(f, k);
      if (!f) begin
         hold_valid(1);
         handshake(1'b0);
      end else begin
         fail_hold(1);
      end

      // Randomized traffic: mixed backpressure, continuous mode and failures.
      for (int t = 0; t < 20; t++) begin
         idle_cycles($urandom_range(0, 3));
         start_idle();
         do_collect(W + D - 1, f, k);
         after_collect(f, k);
         cont = 1'b1;
         for (int j = 0; j < 6 && !f && cont; j++) begin
            hold_valid($urandom_range(0, 4));
            cont = ($urandom_range(0, 2) != 0);
            handshake(cont);
            if (cont) begin
               do_collect(D - 1, f, k);
               after_collect(f, k);
            end
         end
         if (f) fail_hold($urandom_range(0, 3));
         else if (cont) handshake(1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
